sbox_ksa_sched: RTL and testbench
=================================

Name: sbox_ksa_sched

Overview:
Parametrised successor to the identity-fill loader for the RC4 S-box working memory. It fills S[i]=i at one write per cycle. When compiled with key scheduling, it then runs the RC4 KSA swap loop against a single-port synchronous RAM using a registered start key. It sits between the top-level control FSM (start/done) and the S-box RAM port mux, ahead of the PRGA/decrypt stage.

Parameters:
ADDR_W, 8, S-box index/data width; DEPTH = 2**ADDR_W entries.
KEY_LEN, 3, key length in elements of ADDR_W bits each.

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE or DONE
key  in  KEY_LEN*ADDR_W  key; element 0 = most-significant ADDR_W bits
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  ADDR_W  RAM write data
mem_wren  out  1  RAM write enable
mem_rdata  in  ADDR_W  RAM read data; valid in the second cycle after mem_addr is driven
busy  out  1  high from the first FILL cycle through the last KSA cycle
done  out  1  level; high in DONE until the next accepted start or reset

Behaviour:
- Reset (async, reset_n=0): state=IDLE. mem_addr=0, mem_wdata=0, mem_wren=0, busy=0, done=0. Counters i, j and k are zeroed. RAM contents are undefined afterwards.
- All outputs are registered or decoded from registered state. In IDLE and DONE, mem_wren=0.
- IDLE/DONE:
  - On start=1, latch key into key_q, clear i, j and k, drop done, and go to FILL.
  - A key change after acceptance has no effect.
- FILL: mem_addr=i, mem_wdata=i, mem_wren=1, i++ each cycle. After i=DEPTH-1:
  - go to RD_I with i=0, or
  - go to DONE if KSA is compiled out.
- KSA loop, 8 cycles per i:
  - RD_I: mem_addr=i.
  - WAIT_I.
  - LAT_I: si=mem_rdata; j=j+si+key_q[k] (mod DEPTH).
  - RD_J: mem_addr=j.
  - WAIT_J.
  - LAT_J: sj=mem_rdata.
  - WR_I: addr=i, data=sj, wren=1.
  - WR_J: addr=j, data=si, wren=1. Then:
    - k = (k==KEY_LEN-1) ? 0 : k+1, with no divider;
    - if i==DEPTH-1, go to DONE; else i++ and return to RD_I.
- Arithmetic: all index math is ADDR_W bits and wraps silently.
- i==j: both writes hit the same address. The second write stores the original si, so the entry is unchanged (required).
- start while busy: ignored, with no restart and no glitch on outputs.
- Latency: with start accepted at edge t, FILL occupies cycles t+1..t+DEPTH.
  - With KSA: done rises at t+9*DEPTH+1 (2305 for ADDR_W=8).
  - Without KSA: done rises at t+DEPTH+1.
- reset_n low mid-operation: immediate IDLE. A subsequent start reruns fill+KSA from scratch and gives the correct result.

Optional Feature:
SBOX_KSA_EN
- Defined: the FILL→KSA→DONE flow above.
- Undefined: the KSA states, key_q, j, k, si and sj are not synthesised. FILL goes directly to DONE. The key port exists but is unused.

Decomposition:
- Shared package sbox_pkg holds:
  - state enum typedef (IDLE, FILL, RD_I, WAIT_I, LAT_I, RD_J, WAIT_J, LAT_J, WR_I, WR_J, DONE);
  - localparam RD_LAT=2 (read-to-data cycles), reused by the PRGA block;
  - function ksa_j(j, si, kb) returning (j+si+kb) mod 2**ADDR_W.
- No sub-module; the single FSM plus counters is the natural boundary. Key element select is an inline indexed part-select.

Test Plan:
- ADDR_W=8, SBOX_KSA_EN undefined, start pulse → 256 writes with addr=data=0..255 on consecutive cycles; done high at cycle 257 after start; busy low after.
- ADDR_W=2, KEY_LEN=1, key=0, SBOX_KSA_EN defined → final RAM [0,2,3,1]. Covers i==j at i=0 and i=1, and j wrap to 1 at i=3. done at cycle 37.
- ADDR_W=8, KEY_LEN=3, key=24'h000000 vs golden C model → all 256 entries match; exactly 512 KSA writes counted.
- Hold start high for 10 cycles mid-run and change key at cycle 100 → single run; result equals that of the originally latched key.
- Assert reset_n low at cycle 900 (mid-KSA) → all outputs 0 immediately; re-start gives a golden-correct result at the normal latency.
- Start while done=1 → done drops on the next cycle; second run completes identically.

Source files
------------

// File: rtl/sbox_pkg.sv
// Shared definitions for the S-box fill / key-schedule block and the PRGA stage.
// Holds the sequencer state encoding, the RAM read latency and the KSA j update.
package sbox_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        RD_I,
        WAIT_I,
        LAT_I,
        RD_J,
        WAIT_J,
        LAT_J,
        WR_I,
        WR_J,
        DONE
    } sbox_state_e;

    // Cycles from driving mem_addr to mem_rdata being valid.
    localparam int unsigned RD_LAT = 2;

    // j + si + kb, wrapped to addr_w bits.
    function automatic logic [31:0] ksa_j(
        input logic [31:0]  j,
        input logic [31:0]  si,
        input logic [31:0]  kb,
        input int unsigned  addr_w
    );
        logic [31:0] mask;
        mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
        return (j + si + kb) & mask;
    endfunction

endpackage

// File: rtl/sbox_ksa_sched.sv
// S-box loader: fills S[i]=i, then (with SBOX_KSA_EN defined) runs the RC4
// key-scheduling swap loop against a single-port synchronous RAM.
// Optional feature macro: SBOX_KSA_EN (undefined -> fill only, key unused).
module sbox_ksa_sched
    import sbox_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned KEY_LEN = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [KEY_LEN*ADDR_W-1:0]   key,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [ADDR_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    input  logic [ADDR_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic                        done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    sbox_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  i_q, i_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_wren_q, mem_wren_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

`ifdef SBOX_KSA_EN
    localparam int unsigned K_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(KEY_LEN - 1);

    logic [KEY_LEN*ADDR_W-1:0]  key_q, key_d;
    logic [ADDR_W-1:0]          j_q, j_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [ADDR_W-1:0]          si_q, si_d;
    logic [ADDR_W-1:0]          key_byte;

    // Key element k; element 0 sits in the most-significant bits.
    always_comb begin
        key_byte = '0;
        for (int unsigned e = 0; e < KEY_LEN; e++) begin
            if (k_q == K_W'(e)) begin
                key_byte = key_q[(KEY_LEN-1-e)*ADDR_W +: ADDR_W];
            end
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{key, mem_rdata};
`endif

    // Next state, counters and next-cycle RAM port values.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
`ifdef SBOX_KSA_EN
        key_d       = key_q;
        j_d         = j_q;
        k_d         = k_q;
        si_d        = si_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = FILL;
                    i_d         = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wren_d  = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
`ifdef SBOX_KSA_EN
                    key_d       = key;
                    j_d         = '0;
                    k_d         = '0;
`endif
                end
            end

            FILL: begin
                if (i_q == LAST_IDX) begin
`ifdef SBOX_KSA_EN
                    state_d    = RD_I;
                    i_d        = '0;
                    mem_addr_d = '0;
`else
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
`endif
                end else begin
                    i_d         = i_q + 1'b1;
                    mem_addr_d  = i_q + 1'b1;
                    mem_wdata_d = i_q + 1'b1;
                    mem_wren_d  = 1'b1;
                end
            end

`ifdef SBOX_KSA_EN
            RD_I:   state_d = WAIT_I;
            WAIT_I: state_d = LAT_I;

            LAT_I: begin
                si_d       = mem_rdata;
                j_d        = ADDR_W'(ksa_j(32'(j_q), 32'(mem_rdata), 32'(key_byte), ADDR_W));
                mem_addr_d = j_d;
                state_d    = RD_J;
            end

            RD_J:   state_d = WAIT_J;
            WAIT_J: state_d = LAT_J;

            // S[j] is written straight into the WR_I data register, so no sj flop.
            LAT_J: begin
                mem_addr_d  = i_q;
                mem_wdata_d = mem_rdata;
                mem_wren_d  = 1'b1;
                state_d     = WR_I;
            end

            // The second write carries the original S[i], so i==j leaves S unchanged.
            WR_I: begin
                mem_addr_d  = j_q;
                mem_wdata_d = si_q;
                mem_wren_d  = 1'b1;
                state_d     = WR_J;
            end

            WR_J: begin
                k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
                if (i_q == LAST_IDX) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    i_d        = i_q + 1'b1;
                    mem_addr_d = i_q + 1'b1;
                    state_d    = RD_I;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SBOX_KSA_EN
            key_q       <= '0;
            j_q         <= '0;
            k_q         <= '0;
            si_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SBOX_KSA_EN
            key_q       <= key_d;
            j_q         <= j_d;
            k_q         <= k_d;
            si_q        <= si_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sbox_ksa_sched.sv
// Bench for sbox_ksa_sched: an 8-bit/3-element instance and a 2-bit/1-element
// instance, each on its own RAM model with a write scoreboard.
module tb_sbox_ksa_sched;

`ifdef SBOX_KSA_EN
    localparam int LAT8 = 9*256 + 1;
    localparam int NWR8 = 256 + 512;
    localparam int LAT2 = 9*4 + 1;
    localparam int NWR2 = 4 + 8;
`else
    localparam int LAT8 = 256 + 1;
    localparam int NWR8 = 256;
    localparam int LAT2 = 4 + 1;
    localparam int NWR2 = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        start8;
    logic [23:0] key8;
    logic [7:0]  addr8, wdata8, rdata8, rd8_s1;
    logic        wren8, busy8, done8;

    logic        start2;
    logic [1:0]  key2;
    logic [1:0]  addr2, wdata2, rdata2, rd2_s1;
    logic        wren2, busy2, done2;

    sbox_ksa_sched #(.ADDR_W(8), .KEY_LEN(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .key(key8),
        .mem_addr(addr8), .mem_wdata(wdata8), .mem_wren(wren8),
        .mem_rdata(rdata8), .busy(busy8), .done(done8)
    );

    sbox_ksa_sched #(.ADDR_W(2), .KEY_LEN(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .key(key2),
        .mem_addr(addr2), .mem_wdata(wdata2), .mem_wren(wren2),
        .mem_rdata(rdata2), .busy(busy2), .done(done2)
    );

    // Synchronous RAMs: data valid two cycles after the address is presented.
    logic [7:0] ram8 [256];
    logic [1:0] ram2 [4];
    always @(posedge clk) begin
        if (wren8) ram8[addr8] <= wdata8;
        rd8_s1 <= ram8[addr8];
        rdata8 <= rd8_s1;
        if (wren2) ram2[addr2] <= wdata2;
        rd2_s1 <= ram2[addr2];
        rdata2 <= rd2_s1;
    end

    logic [15:0] q8[$];
    logic [3:0]  q2[$];
    logic [7:0]  gold8 [256];
    int errors = 0;
    int checks = 0;
    int wr8_count = 0;
    int wr2_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitors: every RAM write is popped against the expected queue.
    always @(negedge clk) begin
        logic [15:0] e8;
        logic [3:0]  e2;
        if (reset_n && wren8) begin
            wr8_count++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr8_extra: got addr %0h data %0h expected no write", addr8, wdata8);
            end else begin
                e8 = q8.pop_front();
                check("wr8", 32'({addr8, wdata8}), 32'(e8));
            end
        end
        if (reset_n && wren2) begin
            wr2_count++;
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr2_extra: got addr %0h data %0h expected no write", addr2, wdata2);
            end else begin
                e2 = q2.pop_front();
                check("wr2", 32'({addr2, wdata2}), 32'(e2));
            end
        end
    end

    // Reference RC4 fill + KSA; pushes the expected write stream.
    task automatic golden8(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] j, si, sj, kb;
        for (int i = 0; i < 256; i++) begin
            s[i] = 8'(i);
            q8.push_back({8'(i), 8'(i)});
        end
`ifdef SBOX_KSA_EN
        j = '0;
        for (int i = 0; i < 256; i++) begin
            kb = 8'(k >> (8 * (2 - (i % 3))));
            j  = j + s[i] + kb;
            si = s[i];
            sj = s[j];
            q8.push_back({8'(i), sj});
            q8.push_back({j, si});
            s[i] = sj;
            s[j] = si;
        end
`endif
        for (int i = 0; i < 256; i++) gold8[i] = s[i];
    endtask

    task automatic run8(input logic [23:0] k, input int hold, input int chg_at,
                        input logic [23:0] k2, input logic prev_done, input string tag);
        int n;
        golden8(k);
        wr8_count = 0;
        check({tag, "_pre_done"}, 32'(done8), 32'(prev_done));
        key8   = k;
        start8 = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 32'(done8), 32'd0);
        check({tag, "_busy_rise"}, 32'(busy8), 32'd1);
        n = 0;
        while (!done8 && n < 3000) begin
            if (n + 1 >= hold) start8 = 1'b0;
            if (n == chg_at) key8 = k2;
            @(posedge clk); #1;
            n++;
        end
        start8 = 1'b0;
        check({tag, "_done_cycle"}, 32'(n + 1), 32'(LAT8));
        check({tag, "_busy_fall"}, 32'(busy8), 32'd0);
        check({tag, "_wren_idle"}, 32'(wren8), 32'd0);
        check({tag, "_queue_left"}, 32'(q8.size()), 32'd0);
        check({tag, "_write_count"}, 32'(wr8_count), 32'(NWR8));
        for (int i = 0; i < 256; i++)
            check($sformatf("%s_ram[%0d]", tag, i), 32'(ram8[i]), 32'(gold8[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr8"}, 32'(addr8), 32'd0);
        check({tag, "_wdata8"}, 32'(wdata8), 32'd0);
        check({tag, "_wren8"}, 32'(wren8), 32'd0);
        check({tag, "_busy8"}, 32'(busy8), 32'd0);
        check({tag, "_done8"}, 32'(done8), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [1:0] exp2 [4];
        logic [3:0] v2 [12];

        reset_n = 1'b0;
        start8  = 1'b0;
        start2  = 1'b0;
        key8    = '0;
        key2    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_done2", 32'(done2), 32'd0);
        check("reset_wren2", 32'(wren2), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Small instance, key 0: hand-derived write stream and final table.
        v2 = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h0, 4'h0, 4'h5, 4'h5, 4'hB, 4'hE, 4'hD, 4'h6};
        for (int i = 0; i < NWR2; i++) q2.push_back(v2[i]);
`ifdef SBOX_KSA_EN
        exp2 = '{2'd0, 2'd2, 2'd3, 2'd1};
`else
        exp2 = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check("s2_busy_rise", 32'(busy2), 32'd1);
        n = 0;
        while (!done2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("s2_done_cycle", 32'(n + 1), 32'(LAT2));
        check("s2_busy_fall", 32'(busy2), 32'd0);
        check("s2_queue_left", 32'(q2.size()), 32'd0);
        check("s2_write_count", 32'(wr2_count), 32'(NWR2));
        for (int i = 0; i < 4; i++)
            check($sformatf("s2_ram[%0d]", i), 32'(ram2[i]), 32'(exp2[i]));

        // Zero key, plain start pulse.
        run8(24'h000000, 1, -1, 24'h000000, 1'b0, "r1");

        // Restart from DONE, start held 10 cycles, key changed mid-run.
        run8(24'h0A1B2C, 10, 100, 24'hFFFFFF, 1'b1, "r2");

        // Reset 900 cycles after acceptance, then rerun from scratch.
        golden8(24'h5A3C96);
        key8   = 24'h5A3C96;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (900) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q8.delete();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run8(24'h5A3C96, 1, -1, 24'h5A3C96, 1'b0, "r4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
